// File: rtl/lv165_pkg.sv
// lv165_pkg: shared definitions for the 74LV165 scan controller.
//   lv165_state_e : scan FSM states
//   cnt_w(n)      : bits needed to hold counts 0..n
//   DEVICE_BITS   : bits contributed by one LV165 in a daisy chain
package lv165_pkg;

  localparam int unsigned DEVICE_BITS = 8;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_LOW  = 3'd2,
    ST_HIGH = 3'd3,
    ST_DONE = 3'd4
  } lv165_state_e;

  function automatic int unsigned cnt_w(input int unsigned n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/lv165_phase_timer.sv
// lv165_phase_timer: down-counter timing each FSM phase.
//   i_clk      : system clock
//   i_reset    : asynchronous active-low reset
//   i_load     : reload strobe (asserted on every state change)
//   i_load_val : phase length in clocks, >= 1
//   o_last     : high during the last clock of the current phase
module lv165_phase_timer
  import lv165_pkg::*;
#(
  parameter int unsigned MAX_COUNT = 2,
  localparam int unsigned CNT_W    = cnt_w(MAX_COUNT)
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  output logic             o_last
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Loading length-1 makes the phase entered on this edge last exactly
  // i_load_val clocks; the counter parks at zero and never wraps.
  always_comb begin
    cnt_d = cnt_q;
    if (i_load) begin
      cnt_d = i_load_val - CNT_W'(1);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_last = (cnt_q == '0);

endmodule

// File: rtl/lv165_scan_ctrl.sv
// lv165_scan_ctrl: drives a 74LV165 chain (SH/LD, SERCLK) and captures its
// serial output MSB-first into a WIDTH-bit word.
//   i_clk     : system clock          i_reset   : async active-low reset
//   i_start   : scan request (IDLE)   o_busy    : high outside IDLE
//   o_sh_ld_n : LV165 SH/LD           o_serclk  : LV165 CLK
//   i_q       : chain QH              o_data    : last captured word
//   o_valid   : one-cycle pulse when o_data is updated
module lv165_scan_ctrl
  import lv165_pkg::*;
#(
  parameter int unsigned WIDTH       = DEVICE_BITS,
  parameter int unsigned CLK_DIV     = 2,
  parameter int unsigned LOAD_CYCLES = 2
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_start,
  output logic             o_busy,
  output logic             o_sh_ld_n,
  output logic             o_serclk,
  input  logic             i_q,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid
);

  localparam int unsigned PH_MAX = (LOAD_CYCLES > CLK_DIV) ? LOAD_CYCLES : CLK_DIV;
  localparam int unsigned PH_W   = cnt_w(PH_MAX);
  localparam int unsigned BIT_W  = cnt_w(WIDTH);

  lv165_state_e     state_q, state_d;
  logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             sh_ld_n_q, sh_ld_n_d;
  logic             serclk_q, serclk_d;
  logic             q_q;
  logic             ph_load, ph_last;
  logic [PH_W-1:0]  ph_val;

  lv165_phase_timer #(
    .MAX_COUNT(PH_MAX)
  ) u_phase (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_load    (ph_load),
    .i_load_val(ph_val),
    .o_last    (ph_last)
  );

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    sr_d      = sr_q;
    data_d    = data_q;
    valid_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          state_d   = ST_LOAD;
          bit_cnt_d = '0;
        end
      end
      ST_LOAD: begin
        if (ph_last) state_d = ST_LOW;
      end
      ST_LOW: begin
        // Sample before the SERCLK rise that shifts the chain.
        if (ph_last) begin
          sr_d      = {sr_q[WIDTH-2:0], q_q};
          bit_cnt_d = bit_cnt_q + BIT_W'(1);
          state_d   = ST_HIGH;
        end
      end
      ST_HIGH: begin
        if (ph_last) state_d = (bit_cnt_q == BIT_W'(WIDTH)) ? ST_DONE : ST_LOW;
      end
      ST_DONE: begin
        data_d  = sr_q;
        valid_d = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Outputs are decoded from the next state so the pins change on the
    // same edge as the state register, straight from flops.
    ph_load   = (state_d != state_q);
    ph_val    = (state_d == ST_LOAD) ? PH_W'(LOAD_CYCLES) : PH_W'(CLK_DIV);
    sh_ld_n_d = (state_d != ST_LOAD);
    serclk_d  = (state_d == ST_HIGH);
    busy_d    = (state_d != ST_IDLE);
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= '0;
      sr_q      <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      sh_ld_n_q <= 1'b1;
      serclk_q  <= 1'b0;
      q_q       <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      sr_q      <= sr_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      sh_ld_n_q <= sh_ld_n_d;
      serclk_q  <= serclk_d;
      q_q       <= i_q;
    end
  end

  assign o_busy    = busy_q;
  assign o_sh_ld_n = sh_ld_n_q;
  assign o_serclk  = serclk_q;
  assign o_data    = data_q;
  assign o_valid   = valid_q;

endmodule

// File: tb/tb_lv165_scan_ctrl.sv
module tb_lv165_scan_ctrl;

  typedef struct {
    logic [7:0] din;
    logic [7:0] exp;
  } vec_t;

  typedef struct {
    int          lat;
    logic [31:0] data;
    int          rises;
    int          loads;
    int          bad_hi;
    int          bad_lo;
    int          valids;
  } res_t;

  localparam int LAT8  = 2 + 2 * 2 * 8 + 1;
  localparam int LAT16 = 2 + 2 * 3 * 16 + 1;

  int checks   = 0;
  int failures = 0;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // 8-bit, default-parameter DUT and its single-device chain
  logic        start8 = 1'b0;
  logic [7:0]  par8   = '0;
  logic [7:0]  ch8    = '0;
  logic        q8     = 1'b0;
  logic        sh8, sclk8, busy8, valid8;
  logic [7:0]  data8;

  // 16-bit, two-device chain DUT
  logic        start16 = 1'b0;
  logic [15:0] par16   = '0;
  logic [15:0] ch16    = '0;
  logic        q16     = 1'b0;
  logic        sh16, sclk16, busy16, valid16;
  logic [15:0] data16;

  lv165_scan_ctrl #(.WIDTH(8), .CLK_DIV(2), .LOAD_CYCLES(2)) dut8 (
    .i_clk(clk), .i_reset(rst_n), .i_start(start8), .o_busy(busy8),
    .o_sh_ld_n(sh8), .o_serclk(sclk8), .i_q(q8), .o_data(data8), .o_valid(valid8)
  );

  lv165_scan_ctrl #(.WIDTH(16), .CLK_DIV(3), .LOAD_CYCLES(2)) dut16 (
    .i_clk(clk), .i_reset(rst_n), .i_start(start16), .o_busy(busy16),
    .o_sh_ld_n(sh16), .o_serclk(sclk16), .i_q(q16), .o_data(data16), .o_valid(valid16)
  );

  // Behavioural LV165 chains: parallel load on SH/LD low, shift toward QH on
  // SERCLK rise (serial input tied low), QH follows 7 ns later.
  always @(posedge sclk8 or negedge sh8)
    if (!sh8) ch8 <= par8; else ch8 <= {ch8[6:0], 1'b0};
  always @(ch8) begin #7; q8 <= ch8[7]; end

  always @(posedge sclk16 or negedge sh16)
    if (!sh16) ch16 <= par16; else ch16 <= {ch16[14:0], 1'b0};
  always @(ch16) begin #7; q16 <= ch16[15]; end

  // Strobe monitors sampled on the falling edge
  int   rises8 = 0, loads8 = 0, valids8 = 0, bad_hi8 = 0, bad_lo8 = 0;
  int   hi_run8 = 0, lo_run8 = 0;
  logic sclk8_p = 1'b0, sh8_p = 1'b1;
  int   rises16 = 0, valids16 = 0;
  logic sclk16_p = 1'b0;

  always @(negedge clk) begin
    if (sclk8 && !sclk8_p) rises8 <= rises8 + 1;
    if (sclk8) hi_run8 <= hi_run8 + 1;
    else begin
      if (sclk8_p && hi_run8 != 2) bad_hi8 <= bad_hi8 + 1;
      hi_run8 <= 0;
    end
    if (!sh8) lo_run8 <= lo_run8 + 1;
    else begin
      if (!sh8_p) begin
        loads8 <= loads8 + 1;
        if (lo_run8 != 2) bad_lo8 <= bad_lo8 + 1;
      end
      lo_run8 <= 0;
    end
    if (valid8) valids8 <= valids8 + 1;
    sclk8_p <= sclk8;
    sh8_p   <= sh8;
    if (sclk16 && !sclk16_p) rises16 <= rises16 + 1;
    if (valid16) valids16 <= valids16 + 1;
    sclk16_p <= sclk16;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: the chain hands out its bits H first; the receiver collects
  // them in arrival order, first arrival ending up most significant.
  function automatic logic [31:0] model_word(input logic [31:0] din, input int w);
    bit          fifo[$];
    logic [31:0] acc = '0;
    for (int i = w - 1; i >= 0; i--) fifo.push_back(din[i]);
    while (fifo.size() > 0) acc = {acc[30:0], fifo.pop_front()};
    return acc;
  endfunction

  task automatic run_scan8(input logic [7:0] word, input int poke_at, input int tail,
                           output res_t r);
    int r0, l0, v0, h0, b0;
    r0 = rises8; l0 = loads8; v0 = valids8; h0 = bad_hi8; b0 = bad_lo8;
    par8   = word;
    r.lat  = -1;
    r.data = '0;
    @(negedge clk); start8 = 1'b1;
    @(negedge clk); start8 = 1'b0;
    for (int c = 0; c < 200; c++) begin
      if (valid8 && r.lat < 0) begin
        r.lat  = c;
        r.data = {24'd0, data8};
      end
      start8 = (c == poke_at);
      if (r.lat >= 0) break;
      @(negedge clk);
    end
    start8 = 1'b0;
    repeat (tail + 1) @(negedge clk);
    #1;
    r.rises  = rises8 - r0;
    r.loads  = loads8 - l0;
    r.valids = valids8 - v0;
    r.bad_hi = bad_hi8 - h0;
    r.bad_lo = bad_lo8 - b0;
  endtask

  task automatic run_scan16(input logic [15:0] word, output res_t r);
    int r0;
    r0     = rises16;
    par16  = word;
    r.lat  = -1;
    r.data = '0;
    @(negedge clk); start16 = 1'b1;
    @(negedge clk); start16 = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (valid16) begin
        r.lat  = c;
        r.data = {16'd0, data16};
        break;
      end
      @(negedge clk);
    end
    @(negedge clk); #1;
    r.rises = rises16 - r0;
  endtask

  vec_t tbl[11];
  res_t r;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  w6[5];
    logic [15:0] w16[3];
    int          r0, v0, hit, frames, last_v, busy_lo;

    tbl[0] = '{8'hA5, 8'hA5};
    tbl[1] = '{8'h01, 8'h01};
    tbl[2] = '{8'h02, 8'h02};
    tbl[3] = '{8'h04, 8'h04};
    tbl[4] = '{8'h80, 8'h80};
    tbl[5] = '{8'hFF, 8'hFF};
    tbl[6] = '{8'h00, 8'h00};
    for (int i = 7; i < 11; i++) begin
      tbl[i].din = 8'($urandom_range(0, 255));
      tbl[i].exp = 8'(model_word({24'd0, tbl[i].din}, 8));
    end

    // Reset values
    repeat (3) @(negedge clk);
    check("rst busy",   {31'd0, busy8},  0);
    check("rst sh_ld",  {31'd0, sh8},    1);
    check("rst serclk", {31'd0, sclk8},  0);
    check("rst valid",  {31'd0, valid8}, 0);
    check("rst data",   {24'd0, data8},  0);
    check("rst16 data", {16'd0, data16}, 0);
    check("rst16 sh_ld", {31'd0, sh16},  1);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single scans, fixed and random patterns
    for (int i = 0; i < 11; i++) begin
      run_scan8(tbl[i].din, -1, 0, r);
      check($sformatf("scan%0d data", i), r.data, {24'd0, tbl[i].exp});
      check($sformatf("scan%0d latency", i), r.lat, LAT8);
      check($sformatf("scan%0d serclk rises", i), r.rises, 8);
      check($sformatf("scan%0d load pulses", i), r.loads, 1);
      check($sformatf("scan%0d serclk high len", i), r.bad_hi, 0);
      check($sformatf("scan%0d sh_ld low len", i), r.bad_lo, 0);
    end

    // Start pulse while busy must be ignored, not queued
    run_scan8(8'h96, 10, 45, r);
    check("busy start valids", r.valids, 1);
    check("busy start loads", r.loads, 1);
    check("busy start data", r.data, 32'h96);
    check("busy start idle", {31'd0, busy8}, 0);

    // Asynchronous reset after the third SERCLK rise
    par8 = 8'h5A; r0 = rises8; v0 = valids8; hit = 0;
    @(negedge clk); start8 = 1'b1;
    @(negedge clk); start8 = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk); #1;
      if (rises8 - r0 >= 3) begin hit = 1; break; end
    end
    check("rst mid wait 3rd rise", hit, 1);
    check("rst mid pre serclk", {31'd0, sclk8}, 1);
    #1 rst_n = 1'b0;
    #1;
    check("rst mid serclk", {31'd0, sclk8}, 0);
    check("rst mid sh_ld",  {31'd0, sh8},   1);
    check("rst mid busy",   {31'd0, busy8}, 0);
    check("rst mid data",   {24'd0, data8}, 0);
    check("rst mid valid",  {31'd0, valid8}, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    #1;
    check("rst mid no valid", valids8 - v0, 0);
    run_scan8(8'h3C, -1, 0, r);
    check("post rst data", r.data, 32'h3C);
    check("post rst latency", r.lat, LAT8);

    // Two-device chain, slower SERCLK
    w16[0] = 16'h1234;
    w16[1] = 16'($urandom_range(0, 65535));
    w16[2] = 16'($urandom_range(0, 65535));
    for (int i = 0; i < 3; i++) begin
      run_scan16(w16[i], r);
      check($sformatf("w16 scan%0d data", i), r.data, model_word({16'd0, w16[i]}, 16));
      check($sformatf("w16 scan%0d latency", i), r.lat, LAT16);
      check($sformatf("w16 scan%0d rises", i), r.rises, 16);
    end

    // Start held high: back-to-back frames
    for (int i = 0; i < 5; i++) w6[i] = 8'($urandom_range(0, 255));
    par8 = w6[0]; frames = 0; last_v = -1; busy_lo = 0;
    @(negedge clk); start8 = 1'b1;
    for (int c = 0; c < 400 && frames < 5; c++) begin
      @(negedge clk);
      if (!busy8) busy_lo++;
      if (valid8) begin
        check($sformatf("stream%0d data", frames), {24'd0, data8},
              model_word({24'd0, w6[frames]}, 8));
        if (frames > 0) begin
          check($sformatf("stream%0d period", frames), c - last_v, LAT8 + 1);
          check($sformatf("stream%0d busy low clocks", frames), busy_lo, 1);
        end
        busy_lo = 0;
        last_v  = c;
        frames++;
        if (frames < 5) par8 = w6[frames];
      end
    end
    start8 = 1'b0;
    check("stream frames", frames, 5);
    repeat (40) @(negedge clk);
    check("stream end idle", {31'd0, busy8}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
